// File: rtl/fsm_event_counter.sv
// Burst statistics for the sequence detector: counts rising edges of z in BCD,
// tracks current/longest burst length and drives two active-low 7-segment digits.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | z low at the last edge, no burst in progress
// BURST | z high at the last edge, run_len counting up
module fsm_event_counter #(
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             z,
    input  logic             en,
    input  logic             clr,
    output logic             event_p,
    output logic [3:0]       bcd_ones,
    output logic [3:0]       bcd_tens,
    output logic             ovf,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] max_run,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_nxt;
    logic             event_nxt;
    logic             count_inc;

    always_ff @(posedge clk) begin
        if (!aclr) begin
            state   <= IDLE;
            run_len <= '0;
            event_p <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_len <= run_nxt;
            event_p <= event_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = '0;
        event_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (z) begin
                    state_nxt = BURST;
                    run_nxt   = RUN_W'(1);
                    event_nxt = 1'b1;
                end
            end
            BURST: begin
                if (z) begin
                    run_nxt = (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the burst start counts, so enabling mid-burst adds nothing.
    assign count_inc = event_nxt && en;

    always_ff @(posedge clk) begin
        if (!aclr || clr) begin
            bcd_ones <= 4'd0;
            bcd_tens <= 4'd0;
            ovf      <= 1'b0;
        end else if (count_inc) begin
            if (bcd_ones == 4'd9) begin
                bcd_ones <= 4'd0;
                if (bcd_tens == 4'd9) begin
                    bcd_tens <= 4'd0;
                    ovf      <= 1'b1;
                end else begin
                    bcd_tens <= bcd_tens + 4'd1;
                end
            end else begin
                bcd_ones <= bcd_ones + 4'd1;
            end
        end
    end

    // Compared against the next run_len so max_run lands on the same edge.
    always_ff @(posedge clk) begin
        if (!aclr || clr) begin
            max_run <= '0;
        end else if (en && (run_nxt > max_run)) begin
            max_run <= run_nxt;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign hex0 = seg_decode(bcd_ones);
    assign hex1 = seg_decode(bcd_tens);

endmodule

// File: tb/tb_fsm_event_counter.sv
// Bench for fsm_event_counter: fixed vector table, hand-written corner sequences
// and random stimulus compared against a burst-streak reference model.
module tb_fsm_event_counter;

    logic       clk;
    logic       aclr;
    logic       z;
    logic       en;
    logic       clr;
    logic       event_p;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic       ovf;
    logic [3:0] run_len;
    logic [3:0] max_run;
    logic [6:0] hex0;
    logic [6:0] hex1;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_event_counter #(.RUN_W(4)) dut (
        .clk      (clk),
        .aclr     (aclr),
        .z        (z),
        .en       (en),
        .clr      (clr),
        .event_p  (event_p),
        .bcd_ones (bcd_ones),
        .bcd_tens (bcd_tens),
        .ovf      (ovf),
        .run_len  (run_len),
        .max_run  (max_run),
        .hex0     (hex0),
        .hex1     (hex1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10];

    // Reference model: streak = consecutive high samples of z since reset or a low sample.
    int m_streak = 0;
    int m_cnt    = 0;
    int m_ovf    = 0;
    int m_max    = 0;
    int m_ev     = 0;

    function automatic int sat_len(input int s);
        return (s > 15) ? 15 : s;
    endfunction

    task automatic model_edge(input logic a, input logic zi, input logic e, input logic c);
        if (!a) begin
            m_streak = 0; m_cnt = 0; m_ovf = 0; m_max = 0; m_ev = 0;
        end else begin
            m_streak = zi ? m_streak + 1 : 0;
            m_ev = (m_streak == 1) ? 1 : 0;
            if (c) begin
                m_cnt = 0; m_ovf = 0; m_max = 0;
            end else begin
                if (m_ev == 1 && e) begin
                    if (m_cnt == 99) begin
                        m_cnt = 0; m_ovf = 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                if (e && sat_len(m_streak) > m_max) m_max = sat_len(m_streak);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ev, input int cnt, input int ov,
                           input int rl, input int mx);
        chk({tag, " event_p"}, int'(event_p), ev);
        chk({tag, " bcd_ones"}, int'(bcd_ones), cnt % 10);
        chk({tag, " bcd_tens"}, int'(bcd_tens), cnt / 10);
        chk({tag, " ovf"}, int'(ovf), ov);
        chk({tag, " run_len"}, int'(run_len), rl);
        chk({tag, " max_run"}, int'(max_run), mx);
        chk({tag, " hex0"}, int'(hex0), int'(seg_tbl[cnt % 10]));
        chk({tag, " hex1"}, int'(hex1), int'(seg_tbl[cnt / 10]));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_ev, m_cnt, m_ovf, sat_len(m_streak), m_max);
    endtask

    // Drive inputs away from the edge, clock once, sample #1 after the edge.
    task automatic apply(input logic a, input logic zi, input logic e, input logic c);
        aclr = a; z = zi; en = e; clr = c;
        @(posedge clk);
        #1;
        model_edge(a, zi, e, c);
    endtask

    typedef struct {
        logic aclr;
        logic z;
        logic en;
        logic clr;
        int   ev;
        int   cnt;
        int   ov;
        int   rl;
        int   mx;
    } vec_t;

    vec_t vecs [14];
    int   pulses;

    initial begin
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
        seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
        seg_tbl[9] = 7'b0010000;

        // reset held with z high, release with z high, then single 5-cycle burst
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 1, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 1, 1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 2, 2};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 3, 3};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 4, 4};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0, 5, 5};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 5};

        aclr = 1'b0; z = 1'b0; en = 1'b0; clr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].aclr, vecs[i].z, vecs[i].en, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].cnt, vecs[i].ov,
                    vecs[i].rl, vecs[i].mx);
        end
        chk("vec13 hex0 literal", int'(hex0), int'(7'b1111001));

        // saturation and max tracking
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            chk_model("sat");
        end
        chk("sat run_len", int'(run_len), 15);
        chk("sat max_run", int'(max_run), 15);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        chk_model("sat2");
        chk("sat2 max_run", int'(max_run), 15);
        chk("sat2 count", int'(bcd_tens) * 10 + int'(bcd_ones), 2);

        // wrap 99 -> 00 with sticky ovf
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 101; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            chk_model("wrap");
            apply(1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 99) begin
                chk("wrap99 count", int'(bcd_tens) * 10 + int'(bcd_ones), 99);
                chk("wrap99 ovf", int'(ovf), 0);
            end else if (i == 100) begin
                chk("wrap100 count", int'(bcd_tens) * 10 + int'(bcd_ones), 0);
                chk("wrap100 ovf", int'(ovf), 1);
            end
        end
        chk("wrap101 count", int'(bcd_tens) * 10 + int'(bcd_ones), 1);
        chk("wrap101 ovf", int'(ovf), 1);

        // en low: pulses still come, statistics frozen
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            if (event_p) pulses++;
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            apply(1'b1, 1'b0, 1'b0, 1'b0);
            chk_model("en0");
        end
        chk("en0 pulses", pulses, 3);
        chk("en0 count", int'(bcd_tens) * 10 + int'(bcd_ones), 1);
        chk("en0 max_run", int'(max_run), 1);

        // clr on a burst-start edge wins over the increment
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        chk_model("clr");
        chk("clr count", int'(bcd_tens) * 10 + int'(bcd_ones), 0);
        chk("clr ovf", int'(ovf), 0);
        chk("clr max_run", int'(max_run), 0);
        chk("clr event_p", int'(event_p), 1);
        apply(1'b1, 1'b0, 1'b1, 1'b0);

        // en raised mid-burst
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid max before", int'(max_run), 0);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        chk_model("mid");
        chk("mid count", int'(bcd_tens) * 10 + int'(bcd_ones), 0);
        chk("mid max_run", int'(max_run), 3);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid max_run2", int'(max_run), 4);
        apply(1'b1, 1'b0, 1'b1, 1'b0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic ra, rz, re, rc;
            ra = ($urandom_range(0, 199) != 0);
            rz = ($urandom_range(0, 99) < ((i % 400 < 200) ? 60 : 85));
            re = ($urandom_range(0, 9) != 0);
            rc = ($urandom_range(0, 99) == 0);
            apply(ra, rz, re, rc);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_event_counter.md
# fsm_event_counter

Downstream statistics stage for the four-in-a-row sequence detector: consumes the detector's level output `z` and turns it into board-visible statistics. Counts detection bursts (rising edges of `z`) in a two-digit BCD counter, measures the length of the current and longest burst, and drives two active-low 7-segment digits. Sits between the detector's `z` output and the HEX/LEDR pins in the lab top level.

## Interface

- `RUN_W`, default 4: width of the burst-length counters; saturation value is 2^RUN_W-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `aclr`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `z`  in  1  detector output; high while a run of ≥4 equal inputs continues.
- `en`  in  1  statistics enable, active-high.
- `clr`  in  1  statistics clear, synchronous, active-high.
- `event_p`  out  1  one-cycle pulse per detected burst.
- `bcd_ones`  out  4  event count, ones digit, 0–9.
- `bcd_tens`  out  4  event count, tens digit, 0–9.
- `ovf`  out  1  sticky flag, set on 99→00 wrap.
- `run_len`  out  RUN_W  length of the current burst in cycles; 0 when `z` is low.
- `max_run`  out  RUN_W  longest burst seen since the last reset or clear.
- `hex0`  out  7  active-low segments {g..a} for `bcd_ones`.
- `hex1`  out  7  active-low segments {g..a} for `bcd_tens`.

## Operation

- Reset (`aclr`=0 at an edge): state IDLE, `z_q`=0, `event_p`=0, count 00, `ovf`=0, `run_len`=0, `max_run`=0. `hex0`/`hex1` show "0" (7'b1000000). Reset overrides every other input.
- Two-state FSM on the sampled `z`, tracked regardless of `en`:
  - IDLE→BURST when `z`=1. `run_len`←1, `event_p`←1.
  - BURST→BURST when `z`=1. `run_len`←min(`run_len`+1, 2^RUN_W-1). `event_p`←0.
  - BURST→IDLE when `z`=0. `run_len`←0, `event_p`←0.
  - IDLE→IDLE: all of these hold 0.
- `event_p` pulses even when `en`=0. Raising `en` mid-burst does not create an event.
- Event count: on an IDLE→BURST transition with `en`=1, the BCD count increments.
  - Ones 9→0 carries into tens.
  - 99→00 wraps and sets `ovf`, which stays set until reset or `clr`.
- `max_run`: when `en`=1, `max_run` ← max(`max_run`, new `run_len`) at each edge. It saturates together with `run_len`.
- `clr`=1 (with `aclr`=1) clears count, `ovf` and `max_run` at that edge.
  - `clr` takes priority over an increment in the same cycle: the result is 00, not 01.
  - `clr` does not affect the FSM, `run_len` or `event_p`.
- Segment decode is combinational from the registered BCD digits: 0..9 standard patterns; codes 10–15 are unreachable and decode to blank (7'b1111111).

## Timing

- Latency: `z` sampled at edge N → `event_p`, count, `run_len` and `max_run` valid after edge N. This is one cycle after `z` changes.
- `event_p` is exactly one cycle wide per burst; back-to-back bursts need at least one low sample of `z` between them.
- `hex*` follow the BCD registers combinationally, with no added cycle.
- Reset mid-burst: after the edge, the FSM is in IDLE. If `z` is still 1 at the next edge, that edge counts as a new burst (event_p=1, count=01).

## Test plan

- Reset: hold `aclr`=0 for 2 edges with `z`=1 → all outputs 0, `hex0`=`hex1`=7'b1000000. Release with `z`=1 → after the next edge `event_p`=1, count=01.
- Single burst, `en`=1: `z` low 3 cycles, high 5, low → `event_p` high for exactly one cycle, `run_len` 1,2,3,4,5,0, `max_run`=5, count=01, `hex0`=7'b1111001.
- Saturation and max: with `RUN_W`=4, `z` high 20 cycles → `run_len` sticks at 15, `max_run`=15. A following 3-cycle burst leaves `max_run`=15 and gives count=02.
- Wrap: generate 100 bursts (1 high, 1 low) → count 99 after 99 bursts, then 00 with `ovf`=1. A further burst gives count 01 with `ovf` still 1.
- Enable and clear: `en`=0 during 3 bursts → `event_p` pulses 3 times, count and `max_run` unchanged. `clr`=1 on the same edge as a burst start → count 00, `ovf`=0, `max_run`=0, `event_p`=1.
- Enable mid-burst: `z` high with `en`=0, raise `en` after 2 cycles → no count increment, `max_run` starts tracking from the current `run_len`.
